// File: rtl/load_store_unit.sv
// Memory-access stage: turns one ALU load/store request into a registered
// req/ack bus transaction and returns load data or a timeout error to writeback.
module load_store_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0] reqWdata,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memRdata,
  output logic                  respValid,
  output logic [DATA_WIDTH-1:0] respData,
  output logic                  respErr,
  output logic                  stall
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CW-1:0]         r_count;
  logic                  r_memWe;
  logic [ADDR_WIDTH-1:0] r_memAddress;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic [DATA_WIDTH-1:0] r_respData;
  logic                  r_respErr;
  logic                  w_accept;
  logic                  w_timeout;

  assign w_accept  = (r_state == IDLE) && reqValid;
  assign w_timeout = (r_count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // An ack wins over the timeout when both land on the same bus cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (reqValid) begin
          w_nextState = BUS;
        end
      end
      BUS: begin
        if (memAck || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Bus-side registers are loaded only on acceptance, so they stay stable
  // for the whole BUS phase regardless of what upstream presents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memWe      <= 1'b0;
      r_memAddress <= '0;
      r_memWdata   <= '0;
      r_count      <= '0;
    end else if (w_accept) begin
      r_memWe      <= reqWrite;
      r_memAddress <= reqAddress;
      r_memWdata   <= reqWdata;
      r_count      <= '0;
    end else if (r_state == BUS && !memAck && !w_timeout) begin
      r_count      <= r_count + CW'(1);
    end
  end

  // Response registers hold their value between transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_respData <= '0;
      r_respErr  <= 1'b0;
    end else if (r_state == BUS) begin
      if (memAck) begin
        r_respData <= r_memWe ? '0 : memRdata;
        r_respErr  <= 1'b0;
      end else if (w_timeout) begin
        r_respData <= '0;
        r_respErr  <= 1'b1;
      end
    end
  end

  assign reqReady   = (r_state == IDLE);
  assign stall      = !reqReady;
  assign memReq     = (r_state == BUS);
  assign respValid  = (r_state == DONE);
  assign memWe      = r_memWe;
  assign memAddress = r_memAddress;
  assign memWdata   = r_memWdata;
  assign respData   = r_respData;
  assign respErr    = r_respErr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-cycle vector table for the
// load/store/back-to-back flow, plus hand sequences for timeout and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [15:0] reqAddress;
  logic [15:0] reqWdata;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddress;
  logic [15:0] memWdata;
  logic        memAck;
  logic [15:0] memRdata;
  logic        respValid;
  logic [15:0] respData;
  logic        respErr;
  logic        stall;

  int errorCount = 0;
  int checkCount = 0;

  load_store_unit #(
    .DATA_WIDTH    (16),
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .reqAddress(reqAddress),
    .reqWdata  (reqWdata),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddress(memAddress),
    .memWdata  (memWdata),
    .memAck    (memAck),
    .memRdata  (memRdata),
    .respValid (respValid),
    .respData  (respData),
    .respErr   (respErr),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // One row = inputs driven during a cycle plus the outputs expected in that cycle.
  typedef struct {
    logic        rv;
    logic        rw;
    logic [15:0] ra;
    logic [15:0] rd;
    logic        ack;
    logic [15:0] rdat;
    logic        rdy;
    logic        mreq;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mwd;
    logic        rvld;
    logic [15:0] rdata;
    logic        rerr;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic rw, input logic [15:0] ra,
                               input logic [15:0] rd, input logic ack, input logic [15:0] rdat);
    reqValid   = rv;
    reqWrite   = rw;
    reqAddress = ra;
    reqWdata   = rd;
    memAck     = ack;
    memRdata   = rdat;
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    checkOutput($sformatf("row%0d reqReady", idx), {15'd0, reqReady}, {15'd0, v.rdy});
    checkOutput($sformatf("row%0d stall", idx), {15'd0, stall}, {15'd0, !v.rdy});
    checkOutput($sformatf("row%0d memReq", idx), {15'd0, memReq}, {15'd0, v.mreq});
    checkOutput($sformatf("row%0d memWe", idx), {15'd0, memWe}, {15'd0, v.mwe});
    checkOutput($sformatf("row%0d memAddress", idx), memAddress, v.maddr);
    checkOutput($sformatf("row%0d memWdata", idx), memWdata, v.mwd);
    checkOutput($sformatf("row%0d respValid", idx), {15'd0, respValid}, {15'd0, v.rvld});
    checkOutput($sformatf("row%0d respData", idx), respData, v.rdata);
    checkOutput($sformatf("row%0d respErr", idx), {15'd0, respErr}, {15'd0, v.rerr});
  endtask

  // Issues a load from IDLE; leaves the unit in its first BUS cycle at the next negedge.
  task automatic startLoad(input logic [15:0] addr);
    applyStimulus(1'b1, 1'b0, addr, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
  endtask

  initial begin
    int reqCycles;
    bit sawResp;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    //        rv rw ra       rd       ack rdat     rdy mreq mwe maddr    mwd      rvld rdata    rerr
    vecs.push_back('{1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 0});
    vecs.push_back('{1, 1, 16'h1234, 16'hA5A5, 0, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000, 0, 16'hBEEF, 0});
    vecs.push_back('{1, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 1, 1, 16'h1234, 16'hA5A5, 0, 16'hBEEF, 0});
    vecs.push_back('{1, 0, 16'hEEEE, 16'hEEEE, 0, 16'h0000, 0, 1, 1, 16'h1234, 16'hA5A5, 0, 16'hBEEF, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 1, 16'h7777, 0, 1, 1, 16'h1234, 16'hA5A5, 0, 16'hBEEF, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h1234, 16'hA5A5, 1, 16'h0000, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 1, 0, 1, 16'h1234, 16'hA5A5, 0, 16'h0000, 0});
    vecs.push_back('{1, 0, 16'h0100, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h1234, 16'hA5A5, 0, 16'h0000, 0});
    vecs.push_back('{1, 0, 16'h0200, 16'h0000, 1, 16'h0001, 0, 1, 0, 16'h0100, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back('{1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0100, 16'h0000, 1, 16'h0001, 0});
    vecs.push_back('{1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0100, 16'h0000, 0, 16'h0001, 0});
    vecs.push_back('{1, 0, 16'h0300, 16'h0000, 1, 16'h0002, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0001, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0200, 16'h0000, 1, 16'h0002, 0});
    vecs.push_back('{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0200, 16'h0000, 0, 16'h0002, 0});

    // Reset, then five idle cycles with everything at zero.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkRow(100 + i, '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0});
      @(negedge clk);
    end

    // Table-driven load / store / back-to-back flow.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rv, vecs[i].rw, vecs[i].ra, vecs[i].rd, vecs[i].ack, vecs[i].rdat);
      checkRow(i, vecs[i]);
      @(negedge clk);
    end

    // Timeout: no ack, memReq must stay high for exactly 15 cycles.
    startLoad(16'h0ABC);
    reqCycles = 0;
    sawResp = 0;
    for (int i = 0; i < 40 && !sawResp; i++) begin
      if (memReq) reqCycles++;
      if (respValid) begin
        sawResp = 1;
        checkOutput("timeout respErr", {15'd0, respErr}, 16'h0001);
        checkOutput("timeout respData", respData, 16'h0000);
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("timeout respValid seen", {15'd0, sawResp}, 16'h0001);
    checkOutput("timeout memReq cycles", 16'(reqCycles), 16'd15);
    @(negedge clk);
    checkOutput("after timeout reqReady", {15'd0, reqReady}, 16'h0001);
    startLoad(16'h0DEF);
    checkOutput("after timeout memReq", {15'd0, memReq}, 16'h0001);
    checkOutput("after timeout memAddress", memAddress, 16'h0DEF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("after timeout respValid", {15'd0, respValid}, 16'h0001);
    checkOutput("after timeout respErr", {15'd0, respErr}, 16'h0000);
    checkOutput("after timeout respData", respData, 16'h1234);
    @(negedge clk);

    // Ack on the 15th (final) bus cycle must beat the timeout.
    startLoad(16'h0555);
    reqCycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (memReq) reqCycles++;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, (i == 14), (i == 14) ? 16'h0F0F : 16'h0000);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("final-cycle ack memReq cycles", 16'(reqCycles), 16'd15);
    checkOutput("final-cycle ack respValid", {15'd0, respValid}, 16'h0001);
    checkOutput("final-cycle ack respErr", {15'd0, respErr}, 16'h0000);
    checkOutput("final-cycle ack respData", respData, 16'h0F0F);
    @(negedge clk);

    // Reset during the 2nd bus cycle, then a late ack that must be ignored.
    startLoad(16'h0777);
    @(negedge clk);
    checkOutput("pre-reset memReq", {15'd0, memReq}, 16'h0001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5555);
    checkOutput("reset mid-bus memReq", {15'd0, memReq}, 16'h0000);
    checkOutput("reset mid-bus reqReady", {15'd0, reqReady}, 16'h0001);
    checkOutput("reset mid-bus memAddress", memAddress, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("late ack respValid", {15'd0, respValid}, 16'h0000);
    checkOutput("late ack memReq", {15'd0, memReq}, 16'h0000);
    checkOutput("late ack stall", {15'd0, stall}, 16'h0000);
    checkOutput("late ack respData", respData, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the load/store ALU slices (RTV and siblings). Those slices combinationally produce a memory address, plus store data and a write flag.
- This block turns one such request into a registered req/ack transaction on the data-memory bus. It returns read data, or a store completion, to writeback.
- Stalls the pipeline while a transaction is outstanding.
- Aborts with an error flag if memory never acknowledges.

Parameters:
- DATA_WIDTH, 16, width of data bus and of load/store data.
- ADDR_WIDTH, 16, width of memory address.
- TIMEOUT_CYCLES, 15, bus cycles to wait for memAck before aborting; must be at least 1.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- reqValid  input  1  ALU stage presents a memory request this cycle.
- reqReady  output  1  unit can accept a request; high only in IDLE.
- reqWrite  input  1  1 = store, 0 = load.
- reqAddress  input  ADDR_WIDTH  address from the ALU stage (memoryAddress).
- reqWdata  input  DATA_WIDTH  store data.
- memReq  output  1  bus request, held until ack or timeout.
- memWe  output  1  bus write enable, valid while memReq is high.
- memAddress  output  ADDR_WIDTH  registered bus address.
- memWdata  output  DATA_WIDTH  registered bus write data.
- memAck  input  1  memory completed the transfer; memRdata is valid the same cycle for loads.
- memRdata  input  DATA_WIDTH  read data from memory (memoryIn).
- respValid  output  1  one-cycle pulse, transaction finished.
- respData  output  DATA_WIDTH  load data; 0 for stores and on error.
- respErr  output  1  qualified by respValid; 1 = timeout abort.
- stall  output  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high; state goes to IDLE.
  - memReq, memWe, respValid, respErr and stall are 0.
  - memAddress, memWdata and respData are 0; timeout counter is 0.
  - Reset wins over every other input in the same cycle.
- States: IDLE, BUS, DONE (2-bit encoding).
- IDLE:
  - reqReady=1, stall=0.
  - If reqValid=1: latch reqAddress→memAddress, reqWdata→memWdata, reqWrite→memWe; clear counter; go to BUS.
  - If reqValid=0: stay in IDLE.
- BUS:
  - memReq=1; memAddress, memWdata and memWe are held stable the whole time.
  - If memAck=1: respData←(memWe ? 0 : memRdata), respErr←0, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: respData←0, respErr←1, go to DONE.
  - Else: counter increments.
  - memAck has priority over timeout when both occur on the same cycle.
- DONE:
  - respValid=1 for exactly this one cycle; memReq=0; go to IDLE.
  - respData and respErr hold their values until the next DONE or reset.
- Outputs are decoded from registered state: memReq = (state==BUS), respValid = (state==DONE), reqReady = (state==IDLE), stall = !reqReady.
- Latency:
  - Request accepted on edge N; memReq high in cycle N+1.
  - Ack in cycle N+k gives respValid in cycle N+k+1. Minimum 2 cycles from acceptance to respValid.
- Timeout: with no ack, memReq stays high for exactly TIMEOUT_CYCLES cycles, then respValid with respErr=1.
- Ignored inputs:
  - memAck in IDLE or DONE is ignored.
  - reqValid outside IDLE is ignored; the upstream stage must hold its request while stall=1.
  - A request arriving in the DONE cycle is accepted one cycle later, in IDLE.
- Back-to-back: after DONE, a new request may be accepted on the IDLE cycle, so the minimum transaction period is 3 cycles.
- Reset mid-BUS: memReq drops the next cycle; the transaction is abandoned with no respValid. A late memAck after reset is ignored.
- Widths: no arithmetic on data or address, pure transfer. Counter width is clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, reqReady=1, stall=0.
- Load: reqAddress=16'h0040, reqWrite=0; memAck asserted in the first BUS cycle with memRdata=16'hBEEF -> memReq high exactly 1 cycle at address 16'h0040, memWe=0; respValid pulses 2 cycles after acceptance with respData=16'hBEEF, respErr=0.
- Store with 3-cycle wait: reqAddress=16'h1234, reqWdata=16'hA5A5, reqWrite=1; memAck on the 3rd BUS cycle -> memAddress/memWdata/memWe stable for 3 cycles; respValid with respData=0, respErr=0; stall high for 4 cycles.
- Timeout: load with memAck never asserted -> memReq high exactly 15 cycles, then respValid with respErr=1, respData=0; next request is accepted normally.
- Ack on the final timeout cycle (cycle 15) with memRdata=16'h0F0F -> respErr=0, respData=16'h0F0F.
- Other cases, each run separately:
  - Hold reqValid=1 continuously with new addresses -> one transaction every 3 cycles; requests presented while stall=1 are not latched.
  - Assert reset during the 2nd BUS cycle, then pulse memAck the following cycle -> memReq low after reset, no respValid, back to IDLE.
